// File: rtl/wrap_around_leds_n.sv
// wrap_around_leds_n: N-channel LED chaser with hold/rotate-up/rotate-down/bounce modes and pause
//   clk, rst (async, active-high)
//   mode  : 00 hold, 01 rotate-up, 10 rotate-down, 11 bounce
//   pause : freezes prescaler, step counter, position and direction
//   max   : a step fires every (max+1) prescaler ticks
//   leds  : one-hot of pos (plus previous pos when TRAIL_EN is defined)
//   pos   : current lit index
//   step  : one-cycle pulse coincident with each pos update
//   Optional macro TRAIL_EN keeps the previously lit LED on as a trail.
module wrap_around_leds_n #(
    parameter int NUM_LEDS = 4,
    parameter int PRESCALE = 10000000,
    parameter int MAX_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        pause,
    input  logic [MAX_W-1:0]            max,
    output logic [NUM_LEDS-1:0]         leds,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic                        step
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TOP = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LAST_PRE = CW'(PRESCALE - 1);

    logic [CW-1:0]       pre_cnt;
    logic [MAX_W-1:0]    step_cnt;
    logic                dn;
    logic                tick, fire, nxt_dn;
    logic [PW-1:0]       nxt_pos;
    logic [NUM_LEDS-1:0] nxt_leds;
`ifdef TRAIL_EN
    logic [PW-1:0]       prev_pos, nxt_prev;
`endif

    always_comb begin
        tick    = pre_cnt == LAST_PRE && !pause;
        // >= rather than == so lowering max mid-count fires on the next tick
        fire    = tick && step_cnt >= max;
        nxt_pos = pos;
        nxt_dn  = dn;
        if (mode == 2'b01)
            nxt_pos = pos == TOP ? '0 : pos + 1'b1;
        else if (mode == 2'b10)
            nxt_pos = pos == '0 ? TOP : pos - 1'b1;
        else if (mode == 2'b11) begin
            nxt_pos = dn ? (pos == '0 ? PW'(1) : pos - 1'b1) : (pos == TOP ? TOP - 1'b1 : pos + 1'b1);
            nxt_dn  = dn ? pos != '0 : pos == TOP;
        end
`ifdef TRAIL_EN
        nxt_prev = nxt_pos != pos ? pos : prev_pos;
        nxt_leds = (NUM_LEDS'(1) << nxt_pos) | (NUM_LEDS'(1) << nxt_prev);
`else
        nxt_leds = NUM_LEDS'(1) << nxt_pos;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
            pos      <= '0;
            dn       <= 1'b0;
            step     <= 1'b0;
            leds     <= NUM_LEDS'(1);
`ifdef TRAIL_EN
            prev_pos <= '0;
`endif
        end else begin
            step <= fire;
            if (!pause)
                pre_cnt <= pre_cnt == LAST_PRE ? '0 : pre_cnt + 1'b1;
            if (tick)
                step_cnt <= fire ? '0 : step_cnt + 1'b1;
            if (fire) begin
                pos  <= nxt_pos;
                dn   <= nxt_dn;
                leds <= nxt_leds;
`ifdef TRAIL_EN
                prev_pos <= nxt_prev;
`endif
            end
        end
    end
endmodule

// File: tb/tb_wrap_around_leds_n.sv
// tb_wrap_around_leds_n: table-driven scoreboard bench for the LED chaser (NUM_LEDS=4, PRESCALE=2)
module tb_wrap_around_leds_n;
    logic       clk = 1'b0, rst = 1'b0, pause = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] max = 8'd0;
    logic [3:0] leds;
    logic [1:0] pos;
    logic       step;

    wrap_around_leds_n #(.NUM_LEDS(4), .PRESCALE(2), .MAX_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .pause(pause), .max(max),
        .leds(leds), .pos(pos), .step(step)
    );

    always #5 clk = ~clk;

    typedef struct {logic [1:0] p; logic [3:0] l; int gap;} exp_t;
    typedef struct {logic [1:0] mode; logic [7:0] max; int n; logic [39:0] seq; int gap;} vec_t;

    exp_t       q[$];
    exp_t       e;
    vec_t       vecs[6];
    int         nvec = 0, nbad = 0;
    int         cyc = 0, last_cyc = 0;
    logic [1:0] cur_p = 2'd0, mpos = 2'd0, mprev = 2'd0;
    logic [3:0] cur_l = 4'b0001;

    function automatic void chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or posedge rst)
        cyc <= rst ? 0 : cyc + 1;

    // Each step pops one expected record; between steps outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            last_cyc = 0;
            cur_p = 2'd0;
            cur_l = 4'b0001;
            chk("reset_pos", pos, 0);
            chk("reset_leds", leds, 1);
            chk("reset_step", step, 0);
        end else if (step) begin
            if (q.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL unexpected_step: got step with pos=%0d leds=%b, expected no step", pos, leds);
            end else begin
                e = q.pop_front();
                chk("step_pos", pos, e.p);
                chk("step_leds", leds, e.l);
                chk("step_gap", cyc - last_cyc, e.gap);
                cur_p = e.p;
                cur_l = e.l;
            end
            last_cyc = cyc;
        end else begin
            chk("hold_pos", pos, cur_p);
            chk("hold_leds", leds, cur_l);
        end
    end

    task automatic push(input logic [1:0] p, input int gap);
        exp_t x;
`ifdef TRAIL_EN
        if (p != mpos) mprev = mpos;
        x.l = (4'b0001 << p) | (4'b0001 << mprev);
`else
        x.l = 4'b0001 << p;
`endif
        mpos = p;
        x.p = p;
        x.gap = gap;
        q.push_back(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            nvec++;
            nbad++;
            $display("FAIL %s: got %0d steps missing, expected 0 after timeout", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        vecs[0] = '{mode: 2'b01, max: 8'd0, n: 4,  seq: 40'h1230,       gap: 2};
        vecs[1] = '{mode: 2'b10, max: 8'd3, n: 4,  seq: 40'h3210,       gap: 8};
        vecs[2] = '{mode: 2'b11, max: 8'd0, n: 10, seq: 40'h1232101232, gap: 2};
        vecs[3] = '{mode: 2'b01, max: 8'd0, n: 1,  seq: 40'h3,          gap: 2};
        vecs[4] = '{mode: 2'b11, max: 8'd0, n: 2,  seq: 40'h21,         gap: 2};
        vecs[5] = '{mode: 2'b00, max: 8'd1, n: 2,  seq: 40'h11,         gap: 4};
        #1 rst = 1'b1;
        #1;
        chk("init_pos", pos, 0);
        chk("init_leds", leds, 1);
        chk("init_step", step, 0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            max = vecs[i].max;
            for (int k = 0; k < vecs[i].n; k++)
                push(2'(vecs[i].seq[4*(vecs[i].n-1-k) +: 4]), vecs[i].gap);
            if (i == 0) rst = 1'b0;
            drain("vector");
            @(negedge clk);
        end
        mode = 2'b01;
        max = 8'd3;
        push(2'd2, 28);
        push(2'd3, 8);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (20) @(negedge clk);
        pause = 1'b0;
        drain("pause");
        @(negedge clk);
        max = 8'd5;
        push(2'd0, 12);
        drain("max5");
        @(negedge clk);
        push(2'd1, 10);
        repeat (7) @(negedge clk);
        max = 8'd1;
        drain("max_lower");
        @(negedge clk);
        push(2'd2, 4);
        drain("to_pos2");
        chk("pre_rst_pos", pos, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pos", pos, 0);
        chk("async_rst_leds", leds, 1);
        chk("async_rst_step", step, 0);
        repeat (3) @(negedge clk);
        mpos = 2'd0;
        mprev = 2'd0;
        mode = 2'b01;
        max = 8'd0;
        push(2'd1, 2);
        push(2'd2, 2);
        rst = 1'b0;
        drain("after_rst");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/wrap_around_leds_n.md
Name: wrap_around_leds_n

Overview:
- Parametrised N-channel LED chaser: one lit LED steps across a bank of NUM_LEDS outputs at a programmable rate.
- Modes: hold, rotate-up, rotate-down, bounce; pause freezes all timing.
- Drives the board LED bank directly from the top level; switches and buttons feed mode, max and pause.

Parameters:
- NUM_LEDS, 4, number of LED outputs; must be >= 2.
- PRESCALE, 10000000, clk cycles per prescaler tick; must be >= 1.
- MAX_W, 8, width of the max rate input.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- mode  input  2  00 hold, 01 rotate-up, 10 rotate-down, 11 bounce.
- pause  input  1  1 = freeze counters, position and direction.
- max  input  MAX_W  a step fires every (max+1) prescaler ticks.
- leds  output  NUM_LEDS  LED drive; bit i = LED i.
- pos  output  clog2(NUM_LEDS)  current lit index.
- step  output  1  one-cycle pulse coincident with each pos update.

Behaviour:
- Reset (async assert, sync release): pre_cnt=0, step_cnt=0, pos=0, dir=up, step=0, leds = one-hot(0) = ...0001.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt==PRESCALE-1) && !pause.
- Step counter: on tick, if step_cnt >= max then step_cnt<=0 and a step fires; otherwise step_cnt increments.
  - The >= compare means lowering max mid-count fires on the next tick and never wraps through 2^MAX_W.
  - max=0 steps on every tick.
- Step period is (max+1)*PRESCALE cycles. The first step lands (max+1)*PRESCALE cycles after the first un-reset edge.
- pause=1:
  - pre_cnt, step_cnt, pos and dir hold; step=0; leds hold.
  - Pause beats a coincident tick or step.
  - Releasing pause resumes from the held counts with no lost or extra cycles.
- On a fired step, by mode:
  - 00: pos and dir unchanged; step still pulses.
  - 01: pos <= (pos==NUM_LEDS-1) ? 0 : pos+1.
  - 10: pos <= (pos==0) ? NUM_LEDS-1 : pos-1.
  - 11, dir=up: pos+1; at NUM_LEDS-1 go to NUM_LEDS-2 and set dir=down.
  - 11, dir=down: pos-1; at 0 go to 1 and set dir=up. No dwell at ends.
- dir changes only in mode 11. Entering bounce keeps the stored dir. Other modes ignore dir.
- Mode changes take effect at the next step; counters are unaffected.
- Outputs are registered: leds, pos and step all update on the same edge. leds is always a function of the registered pos and never all-zero.
- rst asserted mid-run returns everything to reset values immediately (asynchronously). Timing restarts from zero on release.

Optional Feature:
- Macro TRAIL_EN.
- Defined: extra register prev_pos, loaded with the old pos on every step where pos changes. leds = one-hot(pos) | one-hot(prev_pos), so two LEDs are lit after the first move.
  - Reset: prev_pos=0, leds=...0001.
  - Mode 00 steps do not update prev_pos.
  - Pause holds prev_pos.
- Not defined: no prev_pos register; leds = one-hot(pos) only.

Test Plan (NUM_LEDS=4, PRESCALE=2, MAX_W=8 unless noted):
- Rotate-up: rst 5 cycles then release, mode=01, max=0, pause=0 -> step every 2 cycles; leds 0001,0010,0100,1000,0001; first step 2 cycles after release.
- Rotate-down and rate: mode=10, max=3 -> step every 8 cycles; pos 0,3,2,1,0; step high exactly 1 cycle per update.
- Bounce: mode=11, max=0 -> pos 0,1,2,3,2,1,0,1; then switch to mode 01 at pos=2 with dir=down -> next pos 3; switch back to 11 -> continues down from 3.
- Pause: pause=1 for 20 cycles mid-period -> pos/leds unchanged, step=0; after release the next step arrives exactly the remaining cycles later. Lower max from 5 to 1 while step_cnt=4 -> step on the next tick.
- Reset mid-run: assert rst asynchronously between edges with pos=2 -> leds=0001, pos=0, step=0 before the next clk edge; normal stepping resumes after release.
- TRAIL_EN defined, mode=01: leds 0001, 0011, 0110, 1100, 1001; mode 00 steps leave leds unchanged.
